// File: rtl/seg_scan_cntrl.sv
// Multiplexed seven-segment scan controller: steps a latched snapshot of digit codes
// across NUM_DIGITS active-low anodes with a programmable dwell and blanking guard.
module seg_scan_cntrl #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000,
    parameter int GUARD      = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    scan_en,
    input  logic [3*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   digit_en_in,
    input  logic                    load,
    output logic [2:0]              code_out,
    output logic                    blank_out,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [2:0]              digit_idx,
    output logic                    frame_done,
    output logic                    ld_ack
);

    localparam int CNT_MAX = (PRESCALE > GUARD) ? PRESCALE : GUARD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = (GUARD > 0) ? CNT_W'(GUARD - 1) : '0;
    localparam logic [2:0]       IDX_LAST   = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_GUARD
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2:0]              idx_q, idx_d;
    logic                    pending_q, pending_d;
    logic [3*NUM_DIGITS-1:0] snap_q, snap_d;
    logic [NUM_DIGITS-1:0]   snap_en_q, snap_en_d;
    logic [2:0]              code_q, code_d;
    logic                    blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
    logic                    frame_done_q, ld_ack_q;
    logic                    advance, wrap, commit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        advance = 1'b0;
        if (!scan_en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                ST_SCAN: begin
                    if (cnt_q == SCAN_LAST) begin
                        cnt_d = '0;
                        if (GUARD == 0) advance = 1'b1;
                        else            state_d = ST_GUARD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_GUARD: begin
                    if (cnt_q == GUARD_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_SCAN;
                        advance = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
        wrap = advance && (idx_q == IDX_LAST);
        if (advance) idx_d = wrap ? 3'd0 : idx_q + 3'd1;
    end

    // A pending request commits on any idle edge; while scanning only at the frame wrap,
    // where a same-cycle load also commits so the display never tears mid-frame.
    always_comb begin
        commit    = (pending_q && (state_q == ST_IDLE)) || ((pending_q || load) && wrap);
        pending_d = commit ? 1'b0 : (pending_q || load);
        snap_d    = commit ? digits_in   : snap_q;
        snap_en_d = commit ? digit_en_in : snap_en_q;

        code_d  = code_q;
        an_n_d  = '1;
        blank_d = 1'b1;
        case (state_d)
            ST_IDLE: code_d = 3'd0;
            ST_SCAN: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (idx_d == 3'(i)) begin
                        code_d    = snap_d[3*i +: 3];
                        an_n_d[i] = ~snap_en_d[i];
                        blank_d   = ~snap_en_d[i];
                    end
                end
            end
            default: code_d = code_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            pending_q    <= 1'b0;
            snap_q       <= '0;
            snap_en_q    <= '0;
            code_q       <= 3'd0;
            blank_q      <= 1'b1;
            an_n_q       <= '1;
            frame_done_q <= 1'b0;
            ld_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            snap_q       <= snap_d;
            snap_en_q    <= snap_en_d;
            code_q       <= code_d;
            blank_q      <= blank_d;
            an_n_q       <= an_n_d;
            frame_done_q <= wrap;
            ld_ack_q     <= commit;
        end
    end

    assign code_out   = code_q;
    assign blank_out  = blank_q;
    assign an_n       = an_n_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;
    assign ld_ack     = ld_ack_q;

endmodule

// File: tb/tb_seg_scan_cntrl.sv
// Directed bench for seg_scan_cntrl with NUM_DIGITS=4, PRESCALE=3, GUARD=1.
module tb_seg_scan_cntrl;

    logic        clk = 1'b0;
    logic        reset, scan_en, load;
    logic [11:0] digits_in;
    logic [3:0]  digit_en_in;
    logic [2:0]  code_out;
    logic        blank_out;
    logic [3:0]  an_n;
    logic [2:0]  digit_idx;
    logic        frame_done, ld_ack;

    int checks   = 0;
    int failures = 0;

    // Snapshot data sets; digit 0 is the least significant 3-bit field.
    logic [11:0] sa = {3'd0, 3'd6, 3'd4, 3'd1};
    logic [11:0] sb = {3'd3, 3'd5, 3'd2, 3'd7};
    logic [11:0] sc = {3'd1, 3'd7, 3'd6, 3'd5};
    logic [11:0] sx = {3'd2, 3'd2, 3'd2, 3'd2};
    logic [11:0] sd = 12'hFFF;
    logic [11:0] se = {3'd4, 3'd5, 3'd6, 3'd2};

    seg_scan_cntrl #(
        .NUM_DIGITS(4),
        .PRESCALE  (3),
        .GUARD     (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_en    (scan_en),
        .digits_in  (digits_in),
        .digit_en_in(digit_en_in),
        .load       (load),
        .code_out   (code_out),
        .blank_out  (blank_out),
        .an_n       (an_n),
        .digit_idx  (digit_idx),
        .frame_done (frame_done),
        .ld_ack     (ld_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [3:0] e_an, input logic [2:0] e_code,
                              input logic e_blk, input logic [2:0] e_idx, input logic e_fd,
                              input logic e_ack);
        chk({tag, ".an_n"}, 32'(an_n), 32'(e_an));
        chk({tag, ".code"}, 32'(code_out), 32'(e_code));
        chk({tag, ".blank"}, 32'(blank_out), 32'(e_blk));
        chk({tag, ".idx"}, 32'(digit_idx), 32'(e_idx));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'(e_fd));
        chk({tag, ".ld_ack"}, 32'(ld_ack), 32'(e_ack));
    endtask

    initial begin
        logic [11:0] sv;
        logic [3:0]  ev, ean;
        logic [2:0]  ecode;
        logic        eblk;
        int          seg, d, ph;

        reset = 1'b1; scan_en = 1'b0; load = 1'b0; digits_in = '0; digit_en_in = '0;
        tick(); tick();
        expect_all("reset", 4'hF, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0);
        reset = 1'b0;
        tick(); tick(); tick();
        expect_all("idle", 4'hF, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0);

        // Idle load: ack two cycles after load is presented.
        digits_in = sa; digit_en_in = 4'hF; load = 1'b1;
        tick();
        load = 1'b0;
        chk("idle_ack_c1", 32'(ld_ack), 32'd0);
        tick();
        chk("idle_ack_c2", 32'(ld_ack), 32'd1);
        tick();
        expect_all("idle_after_ack", 4'hF, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0);

        scan_en = 1'b1;
        tick();
        // Six frames: A x3 (mid-frame load at 37, data changed at 40), B with 1010, C x2.
        for (int cyc = 0; cyc < 96; cyc++) begin
            seg = cyc % 16; d = seg / 4; ph = seg % 4;
            if (cyc < 48)      begin sv = sa; ev = 4'hF; end
            else if (cyc < 64) begin sv = sb; ev = 4'hA; end
            else               begin sv = sc; ev = 4'hF; end
            ecode = sv[d*3 +: 3];
            if (ph < 3) begin
                ean  = ev[d] ? ~(4'b0001 << d) : 4'hF;
                eblk = ~ev[d];
            end else begin
                ean  = 4'hF;
                eblk = 1'b1;
            end
            expect_all($sformatf("scan@%0d", cyc), ean, ecode, eblk, 3'(d),
                       (seg == 0) && (cyc != 0), (cyc == 48) || (cyc == 64));
            if (cyc == 37) begin load = 1'b1; digits_in = sx; digit_en_in = 4'hF; end
            if (cyc == 38) load = 1'b0;
            if (cyc == 40) begin digits_in = sb; digit_en_in = 4'hA; end
            if (cyc == 63) begin load = 1'b1; digits_in = sc; digit_en_in = 4'hF; end
            if (cyc == 64) begin load = 1'b0; digits_in = sd; end
            tick();
        end

        // Into digit 2, request a load, then drop scan_en mid-digit.
        for (int i = 0; i < 9; i++) tick();
        expect_all("d2_lit", 4'b1011, 3'd7, 1'b0, 3'd2, 1'b0, 1'b0);
        load = 1'b1; digits_in = se;
        tick();
        load = 1'b0;
        expect_all("d2_pending", 4'b1011, 3'd7, 1'b0, 3'd2, 1'b0, 1'b0);
        scan_en = 1'b0;
        tick();
        expect_all("drop", 4'hF, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0);
        tick();
        expect_all("idle_commit", 4'hF, 3'd0, 1'b1, 3'd0, 1'b0, 1'b1);
        scan_en = 1'b1;
        tick();
        expect_all("restart_d0", 4'b1110, 3'd2, 1'b0, 3'd0, 1'b0, 1'b0);
        tick(); tick(); tick();
        expect_all("restart_guard", 4'hF, 3'd2, 1'b1, 3'd0, 1'b0, 1'b0);
        tick();
        expect_all("restart_d1", 4'b1101, 3'd6, 1'b0, 3'd1, 1'b0, 1'b0);

        // Reset mid-scan clears the snapshot too.
        reset = 1'b1;
        tick();
        expect_all("rst_mid", 4'hF, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        expect_all("post_rst_d0", 4'hF, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0);
        tick(); tick(); tick(); tick();
        expect_all("post_rst_d1", 4'hF, 3'd0, 1'b1, 3'd1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
